dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//   Memory-side responder for the CPU's mem-stage data port. Serves one load or
//   store at a time from an internal word-addressed RAM, inserting a fixed
//   number of wait cycles. Drives stall to the hazard unit while a request is
//   outstanding, so the pipeline holds aluoutM/writedataM until ready pulses.
// PARAMETERS
//   DEPTH   1024  RAM depth in 32-bit words (power of 2, >=2)
//   LATENCY 2     wait cycles between accept and response (0..15)
// PORTS
//   clk    in   1   clock, rising edge
//   rst    in   1   asynchronous, active-low reset
//   req    in   1   request valid; held with fields stable until ready
//   we     in   1   1=store, 0=load
//   be     in   4   byte enables for stores (bit i -> wdata[8i+7:8i])
//   addr   in   32  byte address; addr[1:0] ignored, word = addr[31:2]
//   wdata  in   32  store data (writedataM)
//   rdata  out  32  load data (readdataM), valid when ready & ~we
//   ready  out  1   one-cycle response pulse
//   stall  out  1   req & ~ready (combinational), to hazard unit
//   err    out  1   with ready: word index >= DEPTH
// BEHAVIOUR
//   Reset (rst=0, async): state=IDLE, cnt=0, ready=0, err=0, rdata=0.
//     RAM contents are not reset. Reset mid-request aborts it; no write lands.
//   FSM states IDLE, WAIT, RESP:
//     IDLE: req=1 -> capture we/be/addr/wdata; LATENCY>0 -> WAIT with
//       cnt=LATENCY-1; LATENCY=0 -> RESP. req=0 -> stay.
//     WAIT: cnt!=0 -> cnt-1; cnt==0 -> RESP. Input changes are ignored.
//     RESP: ready=1 for exactly this cycle; next state is always IDLE.
//   Latency: accepted at edge T -> ready high in cycle T+LATENCY+1.
//     Back-to-back requests are separated by at least one IDLE cycle.
//   Store: performed at the edge that leaves RESP. Only bytes with be[i]=1 are
//     written. be=4'b0000 is a legal no-op that still completes.
//   Load: rdata is registered and updates on entry to RESP. It holds its
//     value until the next load completes. Stores never change rdata.
//   Out of range (word index >= DEPTH): write suppressed, load returns
//     32'h0, err=1 during the RESP cycle. err=0 at all other times.
//   Address wrap: none. Index is not truncated modulo DEPTH.
//   stall is derived from live req, so stall=0 whenever req=0, including in
//     WAIT after an illegal early drop of req. An early drop does not cancel
//     the captured request: it still runs to RESP.
//   Only one request is outstanding. There is no queue and no
//     read-during-write hazard.
// TESTING
//   1 Reset: rst=0 then release -> ready=0, err=0, rdata=0, stall=req.
//   2 LATENCY=2: store addr=0x10, wdata=0xDEADBEEF, be=F at T -> ready at
//     T+3 and stall=1 in T..T+2. Then load 0x10 -> rdata=0xDEADBEEF with
//     ready.
//   3 Byte enables: word 0x10 = 0xDEADBEEF, then store be=4'b0101,
//     wdata=0x11223344 -> load 0x10 returns 0xDE22BE44.
//   4 Out of range, DEPTH=1024: store to 0x1000 -> err=1 with ready, RAM
//     unchanged. Load 0x1000 -> rdata=0, err=1.
//   5 LATENCY=0: load accepted at T -> ready at T+1. Keep req high
//     continuously -> ready pulses every 2 cycles.
//   6 Reset mid-op: store 0x20=0xCAFEF00D, assert rst in WAIT -> later load
//     0x20 returns the old value and the FSM restarts cleanly.

Source files
------------

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - single-outstanding data-memory responder with fixed wait latency
module dmem_responder #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        ready_o,
    output logic        stall_o,
    output logic        err_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;

    // Captured request; held from accept until the edge that leaves RESP.
    logic        we_q;
    logic [3:0]  be_q;
    logic [29:0] word_q;
    logic [31:0] wdata_q;
    logic        oor_q;
    logic [31:0] rdata_q;

    logic [31:0] mem [DEPTH];

    // Source of the load that completes on entry to RESP: with zero latency the
    // request enters RESP straight from IDLE, before the capture registers load.
    logic        ld_we;
    logic [29:0] ld_word;
    logic        ld_oor;
    logic        enter_resp;

    // Byte offset is irrelevant for a word-addressed RAM.
    logic        unused_addr_bits;
    assign unused_addr_bits = ^addr_i[1:0];

    // State and wait-counter register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: accept in IDLE, count down in WAIT, one cycle in RESP
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (req_i) begin
                    if (LATENCY > 0) begin
                        state_d = WAIT;
                        cnt_d   = 4'(LATENCY - 1);
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs: ready is the RESP state, stall follows live req
    always_comb begin
        ready_o = (state_q == RESP);
        err_o   = (state_q == RESP) && oor_q;
        stall_o = req_i && (state_q != RESP);
        rdata_o = rdata_q;
    end

    // Load-source selection for the completing request
    always_comb begin
        ld_we      = (state_q == IDLE) ? we_i : we_q;
        ld_word    = (state_q == IDLE) ? addr_i[31:2] : word_q;
        ld_oor     = ({2'b00, ld_word} >= 32'(DEPTH));
        enter_resp = (state_d == RESP) && (state_q != RESP);
    end

    // Request capture and registered load data
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            we_q    <= 1'b0;
            be_q    <= 4'd0;
            word_q  <= 30'd0;
            wdata_q <= 32'd0;
            oor_q   <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            if ((state_q == IDLE) && req_i) begin
                we_q    <= we_i;
                be_q    <= be_i;
                word_q  <= addr_i[31:2];
                wdata_q <= wdata_i;
                oor_q   <= ({2'b00, addr_i[31:2]} >= 32'(DEPTH));
            end
            if (enter_resp && !ld_we) begin
                rdata_q <= ld_oor ? 32'd0 : mem[ld_word[AW-1:0]];
            end
        end
    end

    // Store commits at the edge leaving RESP; out-of-range stores are dropped
    always_ff @(posedge clk_i) begin
        if ((state_q == RESP) && we_q && !oor_q) begin
            for (int i = 0; i < 4; i++) begin
                if (be_q[i]) begin
                    mem[word_q[AW-1:0]][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - randomized self-checking bench with behavioural memory model
module tb_dmem_responder;

    localparam int DEPTH_A = 1024;
    localparam int LAT_A   = 2;
    localparam int DEPTH_B = 16;
    localparam int LAT_B   = 0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_a, req_b, we;
    logic [3:0]  be;
    logic [31:0] addr, wdata;
    logic [31:0] rdata_a, rdata_b;
    logic        ready_a, ready_b, stall_a, stall_b, err_a, err_b;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem_a [int];
    logic [31:0] mem_b [int];
    logic [31:0] rd_a_ref = 32'd0;
    logic [31:0] rd_b_ref = 32'd0;

    typedef struct {
        bit          st;
        logic [3:0]  b;
        logic [31:0] a;
        logic [31:0] d;
    } op_t;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(DEPTH_A), .LATENCY(LAT_A)) u_a (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req_a), .we_i(we), .be_i(be),
        .addr_i(addr), .wdata_i(wdata), .rdata_o(rdata_a), .ready_o(ready_a),
        .stall_o(stall_a), .err_o(err_a)
    );

    dmem_responder #(.DEPTH(DEPTH_B), .LATENCY(LAT_B)) u_b (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req_b), .we_i(we), .be_i(be),
        .addr_i(addr), .wdata_i(wdata), .rdata_o(rdata_b), .ready_o(ready_b),
        .stall_o(stall_b), .err_o(err_b)
    );

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] b);
        for (int i = 0; i < 4; i++) if (b[i]) o[8*i +: 8] = d[8*i +: 8];
        return o;
    endfunction

    function automatic bit is_oor(input bit fast, input logic [31:0] a);
        longint w;
        w = longint'(a[31:2]);
        return w >= (fast ? DEPTH_B : DEPTH_A);
    endfunction

    // Reference: updates the model memory and returns the expected rdata/err
    task automatic model(input bit fast, input op_t op, output logic [31:0] exp_rd, output logic exp_err);
        int w;
        logic [31:0] old;
        w = int'(op.a[31:2]);
        exp_err = is_oor(fast, op.a);
        if (op.st) begin
            if (!exp_err) begin
                if (fast) begin
                    old = mem_b.exists(w) ? mem_b[w] : 32'd0;
                    mem_b[w] = merge(old, op.d, op.b);
                end else begin
                    old = mem_a.exists(w) ? mem_a[w] : 32'd0;
                    mem_a[w] = merge(old, op.d, op.b);
                end
            end
        end else begin
            if (fast) rd_b_ref = exp_err ? 32'd0 : mem_b[w];
            else      rd_a_ref = exp_err ? 32'd0 : mem_a[w];
        end
        exp_rd = fast ? rd_b_ref : rd_a_ref;
    endtask

    // Drives one request, reports latency (cycles after accept edge) and observations
    task automatic run_txn(input bit fast, input op_t op, input bit drop,
                           output int lat, output logic [31:0] rd, output logic er, output bit ok);
        ok = 1'b1; lat = -1; rd = 'x; er = 1'bx;
        @(negedge clk);
        we = op.st; be = op.b; addr = op.a; wdata = op.d;
        if (fast) req_b = 1'b1; else req_a = 1'b1;
        #1;
        if ((fast ? stall_b : stall_a) !== 1'b1) ok = 1'b0;
        @(posedge clk);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (drop) begin req_a = 1'b0; req_b = 1'b0; end
            #1;
            if ((fast ? ready_b : ready_a) === 1'b1) begin
                lat = k;
                rd  = fast ? rdata_b : rdata_a;
                er  = fast ? err_b : err_a;
                if ((fast ? stall_b : stall_a) !== 1'b0) ok = 1'b0;
                break;
            end
            if ((fast ? stall_b : stall_a) !== (fast ? req_b : req_a)) ok = 1'b0;
            if ((fast ? err_b : err_a) !== 1'b0) ok = 1'b0;
        end
        req_a = 1'b0; req_b = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; req_a = 1'b1; req_b = 1'b0;
        we = 1'b0; be = 4'h0; addr = 32'd0; wdata = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        total++; if (ready_a !== 1'b0 || ready_b !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b/%b exp=0/0", ready_a, ready_b); end
        total++; if (err_a !== 1'b0 || err_b !== 1'b0) begin bad++; $display("FAIL reset_err got=%b/%b exp=0/0", err_a, err_b); end
        total++; if (rdata_a !== 32'd0 || rdata_b !== 32'd0) begin bad++; $display("FAIL reset_rdata got=%h/%h exp=0", rdata_a, rdata_b); end
        total++; if (stall_a !== 1'b1 || stall_b !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b/%b exp=1/0", stall_a, stall_b); end
        rst_n = 1'b1; req_a = 1'b0;
        #1;
        total++; if (stall_a !== 1'b0) begin bad++; $display("FAIL reset_stall_req0 got=%b exp=0", stall_a); end
    endtask

    task automatic test_store_load;
        op_t ops[$]; int lat; logic [31:0] rd, erd; logic er, eer; bit ok;
        ops.push_back('{1'b1, 4'hF, 32'h10, 32'hDEADBEEF});
        ops.push_back('{1'b0, 4'hF, 32'h10, 32'h0});
        foreach (ops[i]) begin
            run_txn(1'b0, ops[i], 1'b0, lat, rd, er, ok);
            model(1'b0, ops[i], erd, eer);
            total++; if (lat != LAT_A + 1) begin bad++; $display("FAIL sl_latency[%0d] got=%0d exp=%0d", i, lat, LAT_A + 1); end
            total++; if (!ok) begin bad++; $display("FAIL sl_stall[%0d] got=bad exp=req&~ready", i); end
            total++; if (er !== eer) begin bad++; $display("FAIL sl_err[%0d] got=%b exp=%b", i, er, eer); end
            total++; if (rd !== erd) begin bad++; $display("FAIL sl_rdata[%0d] got=%h exp=%h", i, rd, erd); end
        end
        total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL sl_literal got=%h exp=deadbeef", rd); end
    endtask

    task automatic test_byte_enables;
        op_t ops[$]; int lat; logic [31:0] rd, erd; logic er, eer; bit ok;
        ops.push_back('{1'b1, 4'b0101, 32'h10, 32'h11223344});
        ops.push_back('{1'b0, 4'hF,    32'h11, 32'h0});
        ops.push_back('{1'b1, 4'b0000, 32'h10, 32'hFFFFFFFF});
        ops.push_back('{1'b0, 4'hF,    32'h13, 32'h0});
        foreach (ops[i]) begin
            run_txn(1'b0, ops[i], 1'b0, lat, rd, er, ok);
            model(1'b0, ops[i], erd, eer);
            total++; if (lat != LAT_A + 1) begin bad++; $display("FAIL be_latency[%0d] got=%0d exp=%0d", i, lat, LAT_A + 1); end
            total++; if (rd !== erd || er !== eer) begin bad++; $display("FAIL be_result[%0d] got=%h/%b exp=%h/%b", i, rd, er, erd, eer); end
            if (i == 1) begin
                total++; if (rd !== 32'hDE22BE44) begin bad++; $display("FAIL be_literal got=%h exp=de22be44", rd); end
            end
        end
    endtask

    task automatic test_out_of_range;
        op_t ops[$]; int lat; logic [31:0] rd, erd; logic er, eer; bit ok;
        ops.push_back('{1'b1, 4'hF, 32'h1000,     32'h55555555});
        ops.push_back('{1'b0, 4'hF, 32'h10,       32'h0});
        ops.push_back('{1'b0, 4'hF, 32'h1000,     32'h0});
        ops.push_back('{1'b1, 4'hF, 32'hFFC,      32'hA5A5_1234});
        ops.push_back('{1'b0, 4'hF, 32'hFFC,      32'h0});
        ops.push_back('{1'b1, 4'hF, 32'h10,       32'h0BAD0BAD});
        ops.push_back('{1'b0, 4'hF, 32'hFFFFFFFC, 32'h0});
        ops.push_back('{1'b0, 4'hF, 32'h0,        32'h0});
        foreach (ops[i]) begin
            run_txn(1'b0, ops[i], 1'b0, lat, rd, er, ok);
            model(1'b0, ops[i], erd, eer);
            total++; if (lat != LAT_A + 1 || !ok) begin bad++; $display("FAIL oor_timing[%0d] got=lat%0d ok%0d exp=lat%0d ok1", i, lat, ok, LAT_A + 1); end
            total++; if (er !== eer) begin bad++; $display("FAIL oor_err[%0d] got=%b exp=%b", i, er, eer); end
            total++; if (rd !== erd) begin bad++; $display("FAIL oor_rdata[%0d] got=%h exp=%h", i, rd, erd); end
        end
        @(negedge clk); #1;
        total++; if (err_a !== 1'b0) begin bad++; $display("FAIL oor_err_idle got=%b exp=0", err_a); end
    endtask

    task automatic test_latency0;
        op_t ops[$]; int lat; logic [31:0] rd, erd; logic er, eer; bit ok; logic exp_r;
        ops.push_back('{1'b1, 4'hF, 32'h0C, 32'h01020304});
        ops.push_back('{1'b1, 4'hF, 32'h3C, 32'hFEEDFACE});
        ops.push_back('{1'b0, 4'hF, 32'h3C, 32'h0});
        ops.push_back('{1'b1, 4'hF, 32'h40, 32'h77777777});
        ops.push_back('{1'b0, 4'hF, 32'h40, 32'h0});
        ops.push_back('{1'b0, 4'hF, 32'h0C, 32'h0});
        foreach (ops[i]) begin
            run_txn(1'b1, ops[i], 1'b0, lat, rd, er, ok);
            model(1'b1, ops[i], erd, eer);
            total++; if (lat != LAT_B + 1 || !ok) begin bad++; $display("FAIL l0_timing[%0d] got=lat%0d ok%0d exp=lat%0d ok1", i, lat, ok, LAT_B + 1); end
            total++; if (rd !== erd || er !== eer) begin bad++; $display("FAIL l0_result[%0d] got=%h/%b exp=%h/%b", i, rd, er, erd, eer); end
        end
        // Continuous req: responses every other cycle
        @(negedge clk);
        we = 1'b0; be = 4'hF; addr = 32'h3C; req_b = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk); #1;
            exp_r = (k % 2 == 1);
            total++; if (ready_b !== exp_r || stall_b !== !exp_r) begin bad++; $display("FAIL l0_pulse[%0d] got=%b/%b exp=%b/%b", k, ready_b, stall_b, exp_r, !exp_r); end
            if (exp_r) begin
                total++; if (rdata_b !== mem_b[15]) begin bad++; $display("FAIL l0_pulse_rdata[%0d] got=%h exp=%h", k, rdata_b, mem_b[15]); end
            end
        end
        req_b = 1'b0;
        rd_b_ref = mem_b[15];
    endtask

    task automatic test_reset_mid;
        op_t op; int lat; logic [31:0] rd, erd; logic er, eer; bit ok;
        op = '{1'b1, 4'hF, 32'h20, 32'h600D0001};
        run_txn(1'b0, op, 1'b0, lat, rd, er, ok);
        model(1'b0, op, erd, eer);
        @(negedge clk);
        we = 1'b1; be = 4'hF; addr = 32'h20; wdata = 32'hCAFEF00D; req_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++; if (ready_a !== 1'b0 || rdata_a !== 32'd0) begin bad++; $display("FAIL mid_reset_outputs got=%b/%h exp=0/0", ready_a, rdata_a); end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1; req_a = 1'b0;
        rd_a_ref = 32'd0; rd_b_ref = 32'd0;
        repeat (4) begin
            @(negedge clk); #1;
            total++; if (ready_a !== 1'b0) begin bad++; $display("FAIL mid_reset_no_resp got=%b exp=0", ready_a); end
        end
        op = '{1'b0, 4'hF, 32'h20, 32'h0};
        run_txn(1'b0, op, 1'b0, lat, rd, er, ok);
        model(1'b0, op, erd, eer);
        total++; if (lat != LAT_A + 1 || !ok) begin bad++; $display("FAIL mid_restart got=lat%0d ok%0d exp=lat%0d ok1", lat, ok, LAT_A + 1); end
        total++; if (rd !== 32'h600D0001) begin bad++; $display("FAIL mid_old_value got=%h exp=600d0001", rd); end
    endtask

    task automatic test_random;
        op_t op; int lat; logic [31:0] rd, erd; logic er, eer; bit ok; bit drop; int sel, w;
        for (int i = 0; i < 9; i++) begin
            w = (i == 8) ? DEPTH_A - 1 : i;
            op = '{1'b1, 4'hF, 32'(w) << 2, $urandom};
            run_txn(1'b0, op, 1'b0, lat, rd, er, ok);
            model(1'b0, op, erd, eer);
        end
        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(0, 9);
            if (sel <= 7)      w = sel;
            else if (sel == 8) w = DEPTH_A - 1;
            else               w = DEPTH_A + $urandom_range(0, 1000);
            op.st = $urandom_range(0, 1);
            op.b  = 4'($urandom_range(0, 15));
            op.a  = (32'(w) << 2) | 32'($urandom_range(0, 3));
            op.d  = $urandom;
            drop  = ($urandom_range(0, 5) == 0);
            run_txn(1'b0, op, drop, lat, rd, er, ok);
            model(1'b0, op, erd, eer);
            total++; if (lat != LAT_A + 1 || !ok) begin bad++; $display("FAIL rnd_timing[%0d] got=lat%0d ok%0d exp=lat%0d ok1", i, lat, ok, LAT_A + 1); end
            total++; if (rd !== erd || er !== eer) begin bad++; $display("FAIL rnd_result[%0d] got=%h/%b exp=%h/%b", i, rd, er, erd, eer); end
        end
    endtask

    initial begin
        test_reset;
        test_store_load;
        test_byte_enables;
        test_out_of_range;
        test_latency0;
        test_reset_mid;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
